// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner, debouncer and hex key encoder
// Optional auto-repeat while a key is held is built only when KEY_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_DELAY = 250,
  parameter int REPEAT_RATE  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    row_meta_q, row_meta_d;
  logic [3:0]    row_s_q, row_s_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    cand_row_q, cand_row_d;
  logic [1:0]    cand_col_q, cand_col_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [DW-1:0] rel_cnt_q, rel_cnt_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;

  logic          tick;
  logic          row_any;
  logic [1:0]    row_pri;
  logic          rel_sample;
  logic          accept;
  logic [3:0]    accept_code;

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RPT_DELAY_L = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_RATE_L  = RW'(REPEAT_RATE);
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_armed_q, rpt_armed_d;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
`endif

  assign tick       = (slot_q == SLOT_LAST);
  assign row_any    = (row_s_q != 4'hF);
  assign rel_sample = row_s_q[cand_row_q];

  // Lowest-numbered active row wins when several rows are low.
  always_comb begin
    row_pri = 2'd3;
    if (!row_s_q[0])      row_pri = 2'd0;
    else if (!row_s_q[1]) row_pri = 2'd1;
    else if (!row_s_q[2]) row_pri = 2'd2;
  end

  always_comb begin
    row_meta_d  = row_in;
    row_s_d     = row_meta_q;
    slot_d      = tick ? '0 : slot_q + 1'b1;
    state_d     = state_q;
    col_d       = col_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    deb_cnt_d   = deb_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    accept      = 1'b0;
    accept_code = 4'h0;
`ifdef KEY_REPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_armed_d = rpt_armed_q;
`endif
    case (state_q)
      S_SCAN: begin
        if (tick) begin
          if (row_any) begin
            cand_row_d = row_pri;
            cand_col_d = col_q;
            deb_cnt_d  = DW'(1);
            if (DEBOUNCE_CNT == 1) begin
              accept      = 1'b1;
              accept_code = {row_pri, col_q};
            end else begin
              state_d = S_DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      S_DEBOUNCE: begin
        if (tick) begin
          if (row_any && (row_pri == cand_row_q)) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
            if (deb_cnt_q + 1'b1 == DEB_LAST) begin
              accept      = 1'b1;
              accept_code = {cand_row_q, cand_col_q};
            end
          end else begin
            state_d   = S_SCAN;
            col_d     = col_q + 2'd1;
            deb_cnt_d = '0;
          end
        end
      end
      S_HELD: begin
        // Only the held key's row is watched, so other presses are locked out.
        if (tick) begin
          if (rel_sample) begin
`ifdef KEY_REPEAT_EN
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
`endif
            if (rel_cnt_q + 1'b1 == DEB_LAST) begin
              state_d    = S_SCAN;
              col_d      = col_q + 2'd1;
              key_down_d = 1'b0;
              rel_cnt_d  = '0;
            end else begin
              rel_cnt_d = rel_cnt_q + 1'b1;
            end
          end else begin
            rel_cnt_d = '0;
`ifdef KEY_REPEAT_EN
            if (!rpt_armed_q) begin
              if (rpt_cnt_q + 1'b1 == RPT_DELAY_L) begin
                key_valid_d = 1'b1;
                rpt_armed_d = 1'b1;
                rpt_cnt_d   = '0;
              end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
              end
            end else if (rpt_cnt_q + 1'b1 == RPT_RATE_L) begin
              key_valid_d = 1'b1;
              rpt_cnt_d   = '0;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
`endif
          end
        end
      end
      default: state_d = S_SCAN;
    endcase
    if (accept) begin
      state_d     = S_HELD;
      key_valid_d = 1'b1;
      key_code_d  = accept_code;
      key_down_d  = 1'b1;
      deb_cnt_d   = '0;
      rel_cnt_d   = '0;
`ifdef KEY_REPEAT_EN
      rpt_cnt_d   = '0;
      rpt_armed_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_SCAN;
      row_meta_q  <= 4'hF;
      row_s_q     <= 4'hF;
      slot_q      <= '0;
      col_q       <= 2'd0;
      cand_row_q  <= 2'd0;
      cand_col_q  <= 2'd0;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      row_meta_q  <= row_meta_d;
      row_s_q     <= row_s_d;
      slot_q      <= slot_d;
      col_q       <= col_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
`ifdef KEY_REPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
`endif
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed table-driven bench for keypad_scanner with a keypad matrix model
module tb_keypad_scanner;

  localparam int DEB = 3;
  localparam int RD  = 5;
  localparam int RR  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] pressed;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int dbl    = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [15:0] mask_a;
    int          col;
    logic [15:0] mask_b;
    int          b_after;
    int          hold;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic        exp_down;
  } vec_t;

  vec_t vecs [6];

  keypad_scanner #(
    .SCAN_DIV(4), .DEBOUNCE_CNT(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Key index = row*4 + col; a row reads low when a pressed key sits on a driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
  end

  always @(negedge clk) begin
    if (key_valid) pulses <= pulses + 1;
    if (key_valid && prev_valid) dbl <= dbl + 1;
    prev_valid <= key_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int exp_cnt(input int base, input int hold);
    exp_cnt = base;
`ifdef KEY_REPEAT_EN
    begin
      int h;
      h = hold - DEB;
      if (base > 0 && h >= RD) exp_cnt = base + 1 + (h - RD) / RR;
    end
`endif
  endfunction

  task automatic sync_col(input int c);
    logic [3:0] tgt;
    int n;
    tgt = ~(4'b0001 << c);
    n = 0;
    while (col_out == tgt && n < 64) begin @(negedge clk); n++; end
    while (col_out != tgt && n < 64) begin @(negedge clk); n++; end
    chk("sync_col", col_out, tgt);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int p0, lat, n;
    logic [3:0] c0, cexp;
    sync_col(v.col);
    p0 = pulses;
    pressed = v.mask_a;
    lat = -1;
    n = 0;
    for (int t = 0; t < v.hold * 4; t++) begin
      @(negedge clk);
      n++;
      if (key_valid && lat < 0) lat = n;
      if (v.mask_b != 16'h0 && t == v.b_after * 4 - 1) pressed = pressed | v.mask_b;
    end
    chk($sformatf("v%0d_down_held", idx), key_down, v.exp_down);
    chk($sformatf("v%0d_code", idx), key_code, v.exp_code);
    if (v.exp_pulses > 0) chk($sformatf("v%0d_latency", idx), lat, 12);
    pressed = 16'h0;
    repeat (24) @(negedge clk);
    chk($sformatf("v%0d_down_rel", idx), key_down, 0);
    chk($sformatf("v%0d_pulses", idx), pulses - p0, exp_cnt(v.exp_pulses, v.hold));
    c0 = col_out;
    n = 0;
    while (col_out == c0 && n < 8) begin @(negedge clk); n++; end
    cexp = {c0[2:0], c0[3]};
    chk($sformatf("v%0d_col_advance", idx), col_out, cexp);
  endtask

  initial begin
    int p0;
    vec_t vf;
    vecs[0] = '{16'h0040, 2, 16'h0000, 0, 20, 1, 4'h6, 1'b1};
    vecs[1] = '{16'h0001, 0, 16'h0000, 0,  2, 0, 4'h6, 1'b0};
    vecs[2] = '{16'h0808, 3, 16'h1000, 5, 12, 1, 4'h3, 1'b1};
    vecs[3] = '{16'h0020, 1, 16'h0000, 0,  6, 1, 4'h5, 1'b1};
    vecs[4] = '{16'h0020, 1, 16'h0000, 0,  6, 1, 4'h5, 1'b1};
    vecs[5] = '{16'h0200, 1, 16'h0000, 0,  3, 1, 4'h9, 1'b1};

    rst = 1'b0;
    pressed = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_col_out", col_out, 4'b1110);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_down", key_down, 0);
    chk("rst_key_code", key_code, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset in the middle of debouncing key F
    sync_col(3);
    p0 = pulses;
    pressed = 16'h8000;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_col_out", col_out, 4'b1110);
    chk("midrst_key_valid", key_valid, 0);
    chk("midrst_key_down", key_down, 0);
    chk("midrst_key_code", key_code, 0);
    pressed = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (24) @(negedge clk);
    chk("midrst_no_strobe", pulses - p0, 0);
    vf = '{16'h8000, 3, 16'h0000, 0, 5, 1, 4'hF, 1'b1};
    run_vec(vf, 6);

`ifdef KEY_REPEAT_EN
    vf = '{16'h0400, 2, 16'h0000, 0, 17, 1, 4'hA, 1'b1};
    run_vec(vf, 7);
`endif

    chk("no_double_strobe", dbl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
